// File: rtl/sirv_qspi_link_arbiter_if.sv
// One QSPI link-master port: transmit stream, receive stream, transfer format and chip-select control.
// No logic; pure signal bundle.
// master drives the request side, slave returns ready/rx/active.
interface sirv_qspi_link_arbiter_if;
  logic       tx_valid;
  logic [7:0] tx_bits;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_bits;
  logic [7:0] cnt;
  logic [1:0] fmt_proto;
  logic       fmt_endian;
  logic       fmt_iodir;
  logic       cs_set;
  logic       cs_clear;
  logic       cs_hold;
  logic       lock;
  logic       active;

  modport master (
    output tx_valid, tx_bits, cnt, fmt_proto, fmt_endian, fmt_iodir,
           cs_set, cs_clear, cs_hold, lock,
    input  tx_ready, rx_valid, rx_bits, active
  );

  modport slave (
    input  tx_valid, tx_bits, cnt, fmt_proto, fmt_endian, fmt_iodir,
           cs_set, cs_clear, cs_hold, lock,
    output tx_ready, rx_valid, rx_bits, active
  );
endinterface

// File: rtl/sirv_qspi_link_arbiter.sv
// Shares one QSPI phy link between the PIO FIFO path (in0) and the XIP read path (in1).
// Latency: zero-cycle combinational mux in GRANT; handover costs one chip-select release cycle minimum.
// Backpressure: owner sees phy tx_ready directly; non-owner and any requester during SWITCH see ready=0.
module sirv_qspi_link_arbiter #(
  parameter bit RESET_SEL = 1'b1,
  parameter int MAX_WAIT  = 64,
  parameter int WAIT_W    = 7
) (
  input  logic                      clock,
  input  logic                      reset,
  sirv_qspi_link_arbiter_if.slave   io_in0,
  sirv_qspi_link_arbiter_if.slave   io_in1,
  sirv_qspi_link_arbiter_if.master  io_out,
  output logic                      io_sel
);

  typedef enum logic {ST_GRANT, ST_SWITCH} state_t;

  localparam logic [WAIT_W-1:0] LP_MAX      = WAIT_W'(MAX_WAIT);
  localparam bit                LP_FORCE_EN = (MAX_WAIT != 0);

  state_t            r_state, w_state_nxt;
  logic              r_sel, w_sel_nxt;
  logic              r_owned, w_owned_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;

  logic w_own_vld, w_oth_vld, w_own_lock;
  logic w_hs, w_force, w_handover, w_rdy, w_live;

  assign w_live     = ~reset;
  assign w_own_vld  = r_sel ? io_in1.tx_valid : io_in0.tx_valid;
  assign w_oth_vld  = r_sel ? io_in0.tx_valid : io_in1.tx_valid;
  assign w_own_lock = r_sel ? io_in1.lock     : io_in0.lock;

  // An owner beat accepted this cycle always beats a pending handover.
  assign w_hs       = (r_state == ST_GRANT) & w_own_vld & io_out.tx_ready;
  assign w_force    = LP_FORCE_EN & (r_wait_cnt == LP_MAX);
  assign w_handover = (r_state == ST_GRANT) & ~w_own_lock & ~w_hs & w_oth_vld &
                      (~w_own_vld | w_force);

  // Phy-side request mux; SWITCH forces a chip-select release with the old owner's format.
  always_comb begin
    io_out.tx_bits    = r_sel ? io_in1.tx_bits    : io_in0.tx_bits;
    io_out.cnt        = r_sel ? io_in1.cnt        : io_in0.cnt;
    io_out.fmt_proto  = r_sel ? io_in1.fmt_proto  : io_in0.fmt_proto;
    io_out.fmt_endian = r_sel ? io_in1.fmt_endian : io_in0.fmt_endian;
    io_out.fmt_iodir  = r_sel ? io_in1.fmt_iodir  : io_in0.fmt_iodir;
    io_out.cs_set     = r_sel ? io_in1.cs_set     : io_in0.cs_set;
    io_out.cs_hold    = r_sel ? io_in1.cs_hold    : io_in0.cs_hold;
    io_out.cs_clear   = 1'b0;
    io_out.tx_valid   = 1'b0;
    io_out.lock       = 1'b0;
    w_rdy             = 1'b0;
    if (r_state == ST_GRANT) begin
      io_out.tx_valid = w_own_vld & w_live;
      io_out.cs_clear = (r_sel ? io_in1.cs_clear : io_in0.cs_clear) & w_live;
      w_rdy           = io_out.tx_ready & w_live;
    end else begin
      io_out.cs_set   = 1'b1;
      io_out.cs_hold  = 1'b0;
      io_out.cs_clear = w_live;
    end
  end

  // Requester-side returns: only the owner (old owner during SWITCH) sees ready/rx; active needs a beat of its own.
  always_comb begin
    io_in0.rx_bits  = io_out.rx_bits;
    io_in1.rx_bits  = io_out.rx_bits;
    io_in0.tx_ready = w_rdy & ~r_sel;
    io_in1.tx_ready = w_rdy & r_sel;
    io_in0.rx_valid = io_out.rx_valid & w_live & ~r_sel;
    io_in1.rx_valid = io_out.rx_valid & w_live & r_sel;
    io_in0.active   = io_out.active & r_owned & w_live & ~r_sel;
    io_in1.active   = io_out.active & r_owned & w_live & r_sel;
  end

  assign io_sel = r_sel;

  // Next-state: GRANT tracks ownership and starvation, SWITCH waits for the phy to go idle.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_owned_nxt = r_owned;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      ST_GRANT: begin
        if (w_oth_vld) begin
          if (r_wait_cnt != LP_MAX) w_wait_nxt = r_wait_cnt + 1'b1;
        end else begin
          w_wait_nxt = '0;
        end
        if (w_handover) begin
          w_state_nxt = ST_SWITCH;
          w_owned_nxt = 1'b0;
        end else if (w_hs) begin
          w_owned_nxt = 1'b1;
        end
      end
      ST_SWITCH: begin
        if (!io_out.active) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = ~r_sel;
          w_wait_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_GRANT;
    endcase
  end

  // State registers with asynchronous reset back to the reset owner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_GRANT;
      r_sel      <= RESET_SEL;
      r_owned    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_owned    <= w_owned_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

endmodule

// File: tb/tb_sirv_qspi_link_arbiter.sv
// Randomized scoreboard bench for sirv_qspi_link_arbiter against a behavioural model.
// Stimulus pushes the expected per-cycle view; a negedge monitor pops and compares.
// Phases bias valid/lock/ready/active to reach locking, forced handover, long SWITCH and reset.
module tb_sirv_qspi_link_arbiter;
  localparam int MAX_WAIT = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic io_sel;

  sirv_qspi_link_arbiter_if u_in0 ();
  sirv_qspi_link_arbiter_if u_in1 ();
  sirv_qspi_link_arbiter_if u_out ();

  sirv_qspi_link_arbiter #(.RESET_SEL(1'b1), .MAX_WAIT(MAX_WAIT), .WAIT_W(7)) u_dut (
    .clock  (clock),
    .reset  (reset),
    .io_in0 (u_in0),
    .io_in1 (u_in1),
    .io_out (u_out),
    .io_sel (io_sel)
  );

  always #5 clock = ~clock;

  typedef struct {
    int sel, tv, bits, cnt, proto, endian, iodir, cs_set, cs_clr, cs_hold;
    int rdy0, rdy1, rv0, rv1, rb, act0, act1;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Model state: who owns the link, whether a release is in progress, whether the owner has sent a beat, and how long the other side has waited.
  int m_owner  = 1;
  int m_switch = 0;
  int m_owned  = 0;
  int m_wait   = 0;

  function automatic bit pct(int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive random inputs, predict outputs from the model, advance the model.
  task automatic step(input int pv0, input int pv1, input int pl0, input int pl1,
                      input int prdy, input int pact, input int prst);
    int vld[2], bits[2], cnt[2], proto[2], en[2], dir[2];
    int cset[2], cclr[2], chold[2], lck[2];
    int rdy[2], rv[2], ac[2];
    int o_rdy, o_rxv, o_rxb, o_act, rst, own, oth, hs, ho;
    exp_t e;
    @(posedge clock);
    #1;
    vld[0] = pct(pv0); vld[1] = pct(pv1);
    lck[0] = pct(pl0); lck[1] = pct(pl1);
    for (int k = 0; k < 2; k++) begin
      bits[k]  = $urandom_range(255);
      cnt[k]   = $urandom_range(255);
      proto[k] = $urandom_range(2);
      en[k]    = $urandom_range(1);
      dir[k]   = $urandom_range(1);
      cset[k]  = $urandom_range(1);
      cclr[k]  = $urandom_range(1);
      chold[k] = $urandom_range(1);
      rdy[k] = 0; rv[k] = 0; ac[k] = 0;
    end
    o_rdy = pct(prdy);
    o_rxv = $urandom_range(1);
    o_rxb = $urandom_range(255);
    o_act = pct(pact);
    rst   = pct(prst);

    reset = rst[0];
    u_in0.tx_valid = vld[0][0]; u_in1.tx_valid = vld[1][0];
    u_in0.tx_bits = 8'(bits[0]); u_in1.tx_bits = 8'(bits[1]);
    u_in0.cnt = 8'(cnt[0]); u_in1.cnt = 8'(cnt[1]);
    u_in0.fmt_proto = 2'(proto[0]); u_in1.fmt_proto = 2'(proto[1]);
    u_in0.fmt_endian = en[0][0]; u_in1.fmt_endian = en[1][0];
    u_in0.fmt_iodir = dir[0][0]; u_in1.fmt_iodir = dir[1][0];
    u_in0.cs_set = cset[0][0]; u_in1.cs_set = cset[1][0];
    u_in0.cs_clear = cclr[0][0]; u_in1.cs_clear = cclr[1][0];
    u_in0.cs_hold = chold[0][0]; u_in1.cs_hold = chold[1][0];
    u_in0.lock = lck[0][0]; u_in1.lock = lck[1][0];
    u_out.tx_ready = o_rdy[0];
    u_out.rx_valid = o_rxv[0];
    u_out.rx_bits = 8'(o_rxb);
    u_out.active = o_act[0];

    if (rst != 0) begin
      m_owner = 1; m_switch = 0; m_owned = 0; m_wait = 0;
    end
    own = m_owner;
    oth = 1 - own;
    e.sel = own; e.bits = bits[own]; e.cnt = cnt[own]; e.proto = proto[own];
    e.endian = en[own]; e.iodir = dir[own]; e.rb = o_rxb;
    if (rst != 0) begin
      e.tv = 0; e.cs_clr = 0; e.cs_set = cset[own]; e.cs_hold = chold[own];
    end else if (m_switch == 0) begin
      e.tv = vld[own]; e.cs_set = cset[own]; e.cs_clr = cclr[own]; e.cs_hold = chold[own];
      rdy[own] = o_rdy;
      rv[own]  = o_rxv;
      ac[own]  = o_act & m_owned;
      hs = vld[own] & o_rdy;
      ho = (lck[own] == 0) && (hs == 0) && (vld[oth] != 0) &&
           ((vld[own] == 0) || (MAX_WAIT != 0 && m_wait == MAX_WAIT));
      if (ho) begin
        m_switch = 1; m_owned = 0;
      end else if (hs != 0) begin
        m_owned = 1;
      end
      m_wait = (vld[oth] != 0) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
    end else begin
      e.tv = 0; e.cs_set = 1; e.cs_clr = 1; e.cs_hold = 0;
      rv[own] = o_rxv;
      if (o_act == 0) begin
        m_owner = oth; m_switch = 0; m_wait = 0;
      end
    end
    e.rdy0 = rdy[0]; e.rdy1 = rdy[1];
    e.rv0 = rv[0];   e.rv1 = rv[1];
    e.act0 = ac[0];  e.act1 = ac[1];
    exp_q.push_back(e);
  endtask

  task automatic run_phase(input int n, input int pv0, input int pv1, input int pl0,
                           input int pl1, input int prdy, input int pact, input int prst);
    for (int i = 0; i < n; i++) step(pv0, pv1, pl0, pl1, prdy, pact, prst);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("io_sel", io_sel, e.sel);
        chk("out_tx_valid", u_out.tx_valid, e.tv);
        chk("out_tx_bits", u_out.tx_bits, e.bits);
        chk("out_cnt", u_out.cnt, e.cnt);
        chk("out_fmt_proto", u_out.fmt_proto, e.proto);
        chk("out_fmt_endian", u_out.fmt_endian, e.endian);
        chk("out_fmt_iodir", u_out.fmt_iodir, e.iodir);
        chk("out_cs_set", u_out.cs_set, e.cs_set);
        chk("out_cs_clear", u_out.cs_clear, e.cs_clr);
        chk("out_cs_hold", u_out.cs_hold, e.cs_hold);
        chk("in0_tx_ready", u_in0.tx_ready, e.rdy0);
        chk("in1_tx_ready", u_in1.tx_ready, e.rdy1);
        chk("in0_rx_valid", u_in0.rx_valid, e.rv0);
        chk("in1_rx_valid", u_in1.rx_valid, e.rv1);
        chk("in0_rx_bits", u_in0.rx_bits, e.rb);
        chk("in1_rx_bits", u_in1.rx_bits, e.rb);
        chk("in0_active", u_in0.active, e.act0);
        chk("in1_active", u_in1.active, e.act1);
      end
    end
  end

  initial begin
    u_in0.tx_valid = 1'b1; u_in1.tx_valid = 1'b0;
    u_in0.lock = 1'b0; u_in1.lock = 1'b0;
    u_out.tx_ready = 1'b0; u_out.active = 1'b0; u_out.rx_valid = 1'b0;
    // reset held with in0 requesting
    run_phase(3,   100, 0,   0,   0,   100, 50, 100);
    // in1 streams alone, then in0 joins while in1 is idle/unlocked
    run_phase(10,  0,   100, 0,   0,   100, 50, 0);
    run_phase(20,  100, 0,   0,   0,   80,  10, 0);
    // mixed traffic
    run_phase(300, 50,  50,  20,  20,  70,  40, 0);
    // owner locked with both requesting: no handover
    run_phase(200, 100, 100, 100, 100, 60,  30, 0);
    // unlocked contention: forced handovers after the wait bound
    run_phase(400, 100, 100, 0,   0,   85,  20, 0);
    // phy stays active a long time: SWITCH stretches
    run_phase(200, 60,  60,  10,  10,  70,  90, 0);
    // mostly idle requesters
    run_phase(100, 10,  10,  0,   0,   50,  30, 0);
    // reset in the middle of traffic, then recover
    run_phase(50,  70,  70,  0,   0,   50,  90, 0);
    run_phase(2,   70,  70,  0,   0,   50,  90, 100);
    run_phase(150, 60,  60,  20,  20,  70,  40, 0);
    @(negedge clock);
    #1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
